dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DM_DEPTH, default 256, number of 32-bit words in the storage array.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, legal range 1..15, number of clock edges in the access phase.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port req_fun3  input  3  RV32I width/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  initiator takes the response.
REQ-013 SHALL have port rsp_rdata  output  32  load result, extended per fun3; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  request was rejected (misaligned, illegal fun3, out of range).

Function
REQ-015 SHALL implement FSM states IDLE, ACCESS, RESP; req_ready = (state==IDLE); rsp_valid = (state==RESP).
REQ-016 SHALL accept a request on an edge with req_valid && req_ready, latch we/addr/wdata/fun3, load the wait counter with WAIT_CYCLES-1, and go to ACCESS.
REQ-017 SHALL decrement the counter each edge in ACCESS and move to RESP on the edge where the counter is 0, so rsp_valid rises after exactly WAIT_CYCLES edges following the accepting edge.
REQ-018 SHALL perform the memory access (store write or load read) on the ACCESS->RESP edge, using only the latched request fields.
REQ-019 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until an edge with rsp_ready=1, then go to IDLE; the next request is accepted no earlier than the following edge.
REQ-020 SHALL ignore req_* inputs outside IDLE; request inputs may change freely after acceptance.
REQ-021 SHALL index the array with word = addr[31:2], byte lane = addr[1:0].
REQ-022 SHALL produce loads as follows: LB/LBU select byte at lane, sign-/zero-extend to 32 bits; LH/LHU select halfword at addr[1]; LW returns the full word.
REQ-023 SHALL write stores with byte enables: SB writes wdata[7:0] to the lane; SH writes wdata[15:0] to halfword addr[1]; SW writes all 4 bytes; other bytes unchanged.
REQ-024 SHALL flag rsp_err=1 with rsp_rdata=0 and no array write when: halfword access with addr[0]=1; word access with addr[1:0]!=0; fun3 not in {000,001,010,100,101} for loads or {000,001,010} for stores; addr[31:2] >= DM_DEPTH.
REQ-025 SHALL return rsp_rdata=0 and rsp_err=0 for a successful store.
REQ-026 SHALL keep array contents undefined after power-up and unchanged by rst.

Reset
REQ-027 SHALL, when rst=1 at an edge, force state=IDLE, counter=0, rsp_rdata=0, rsp_err=0, hence rsp_valid=0, req_ready=1 after that edge.
REQ-028 SHALL abort any in-flight request on reset; a store reset before its ACCESS->RESP edge SHALL NOT modify the array, and no response SHALL be issued for it.
REQ-029 SHALL NOT accept a request on an edge where rst=1.

Verification
REQ-030 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid 2 edges after each accept, rsp_rdata 0xDEADBEEF, rsp_err 0.
REQ-031 After REQ-030, LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-032 SB 0x11 data 0x00000055 over 0xDEADBEEF, then LW 0x10 -> 0xDEAD55EF.
REQ-033 LW 0x12, LH 0x11, SW 0x400 (DM_DEPTH=256), load fun3=011 -> each rsp_err 1, rsp_rdata 0, following LW 0x10 unchanged.
REQ-034 Hold rsp_ready=0 for 5 cycles in RESP with req_valid=1 -> rsp_valid/rsp_rdata stable, req_ready 0, no second accept; rsp_ready=1 -> IDLE, next accept one edge later.
REQ-035 Accept SW 0x20 data 0x12345678 over known 0x0, assert rst in ACCESS -> no rsp_valid, req_ready 1 after reset edge, later LW 0x20 returns 0x00000000.

Source files
------------

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one RV32I load/store, waits
// WAIT_CYCLES edges, then presents a held response until rsp_ready.
module dmem_responder #(
    parameter int DM_DEPTH    = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_fun3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DM_DEPTH > 1) ? $clog2(DM_DEPTH) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [2:0]    fun3_q, fun3_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;

    logic [31:0]   mem [DM_DEPTH];

    logic [AW-1:0] word_idx;
    logic          in_range;
    logic          fun3_bad;
    logic          misaligned;
    logic          acc_err;
    logic          acc_fire;
    logic          mem_we;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;
    logic [31:0]   ld_data;
    logic [31:0]   wr_shift;
    logic [3:0]    be;

    assign word_idx = addr_q[AW+1:2];
    assign in_range = {2'b00, addr_q[31:2]} < 32'(DM_DEPTH);

    always_comb begin
        fun3_bad = 1'b0;
        if (we_q) begin
            fun3_bad = (fun3_q[2] == 1'b1) || (fun3_q[1:0] == 2'b11);
        end else begin
            fun3_bad = (fun3_q == 3'b011) || (fun3_q == 3'b110) || (fun3_q == 3'b111);
        end
    end

    always_comb begin
        misaligned = 1'b0;
        case (fun3_q[1:0])
            2'b01:   misaligned = addr_q[0];
            2'b10:   misaligned = (addr_q[1:0] != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    assign acc_err  = fun3_bad || misaligned || !in_range;
    // The access happens on the ACCESS->RESP edge only; reset on that edge cancels it.
    assign acc_fire = (state_q == ST_ACCESS) && (cnt_q == 4'd0) && !rst;
    assign mem_we   = acc_fire && we_q && !acc_err;

    assign rd_word  = mem[word_idx];
    assign rd_shift = rd_word >> {addr_q[1:0], 3'b000};
    assign wr_shift = wdata_q << {addr_q[1:0], 3'b000};

    always_comb begin
        ld_data = '0;
        case (fun3_q)
            3'b000:  ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
            3'b001:  ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
            3'b010:  ld_data = rd_word;
            3'b100:  ld_data = {24'd0, rd_shift[7:0]};
            3'b101:  ld_data = {16'd0, rd_shift[15:0]};
            default: ld_data = '0;
        endcase
    end

    always_comb begin
        be = '0;
        case (fun3_q[1:0])
            2'b00:   be = 4'b0001 << addr_q[1:0];
            2'b01:   be = 4'b0011 << addr_q[1:0];
            2'b10:   be = 4'b1111;
            default: be = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        fun3_d  = fun3_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    fun3_d  = req_fun3;
                    cnt_d   = 4'(WAIT_CYCLES - 1);
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    err_d   = acc_err;
                    rdata_d = (acc_err || we_q) ? '0 : ld_data;
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            fun3_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            fun3_q  <= fun3_d;
        end
    end

    // Storage has no reset: contents survive rst and start undefined.
    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (mem_we && be[i]) begin
                mem[word_idx][8*i +: 8] <= wr_shift[8*i +: 8];
            end
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses are queued when a
// request is driven and compared when the responder presents its response.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int WAITC = 2;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [2:0]  req_fun3;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    typedef struct {
        logic        we;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        logic        err;
    } txn_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    dmem_responder #(.DM_DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_fun3  (req_fun3),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic txn_t mk(input logic we, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] d, input logic [31:0] exp, input logic err);
        txn_t t;
        t.we = we; t.f = f; t.a = a; t.d = d; t.exp = exp; t.err = err;
        return t;
    endfunction

    // Drives one request, scrambles the request inputs after acceptance,
    // measures edges until rsp_valid and completes the response handshake.
    task automatic run_txn(input txn_t t, output logic [31:0] rd, output logic er,
                           output int lat, output bit tmo);
        int n;
        tmo = 1'b0; lat = 0; n = 0; rd = '0; er = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_we = t.we; req_addr = t.a; req_wdata = t.d; req_fun3 = t.f;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            tmo = 1'b1;
            req_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_we    = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_fun3  = 3'($urandom);
        while (1) begin
            @(posedge clk);
            #1;
            lat++;
            if (rsp_valid) break;
            if (lat >= 50) begin
                tmo = 1'b1;
                return;
            end
        end
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        n_checks++;
        if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        n_checks++;
        if (rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got=%h exp=0", rsp_rdata); end
        n_checks++;
        if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got=%b exp=0", rsp_err); end
    endtask

    task automatic test_loads_stores();
        txn_t q[$];
        logic [31:0] rd;
        logic er;
        int lat;
        bit tmo;
        exp_t e;
        q.push_back(mk(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0));
        q.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0));
        q.push_back(mk(1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFFFFDE, 1'b0));
        q.push_back(mk(1'b0, 3'b100, 32'h13, 32'h0, 32'h000000DE, 1'b0));
        q.push_back(mk(1'b0, 3'b001, 32'h12, 32'h0, 32'hFFFFDEAD, 1'b0));
        q.push_back(mk(1'b0, 3'b101, 32'h10, 32'h0, 32'h0000BEEF, 1'b0));
        q.push_back(mk(1'b0, 3'b000, 32'h10, 32'h0, 32'hFFFFFFEF, 1'b0));
        q.push_back(mk(1'b1, 3'b000, 32'h11, 32'h00000055, 32'h0, 1'b0));
        q.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0));
        q.push_back(mk(1'b1, 3'b010, 32'h30, 32'h11223344, 32'h0, 1'b0));
        q.push_back(mk(1'b1, 3'b001, 32'h32, 32'hFFFFABCD, 32'h0, 1'b0));
        q.push_back(mk(1'b0, 3'b010, 32'h30, 32'h0, 32'hABCD3344, 1'b0));
        q.push_back(mk(1'b0, 3'b001, 32'h30, 32'h0, 32'h00003344, 1'b0));
        q.push_back(mk(1'b1, 3'b010, 32'h3FC, 32'hA5A5C3C3, 32'h0, 1'b0));
        q.push_back(mk(1'b0, 3'b010, 32'h3FC, 32'h0, 32'hA5A5C3C3, 1'b0));
        foreach (q[i]) begin
            sb.push_back('{rdata: q[i].exp, err: q[i].err});
            run_txn(q[i], rd, er, lat, tmo);
            e = sb.pop_front();
            n_checks++;
            if (tmo || lat != WAITC) begin
                n_fail++; $display("FAIL ls_latency[%0d] got=%0d timeout=%0b exp=%0d", i, lat, tmo, WAITC);
            end
            n_checks++;
            if (rd !== e.rdata) begin n_fail++; $display("FAIL ls_rdata[%0d] got=%h exp=%h", i, rd, e.rdata); end
            n_checks++;
            if (er !== e.err) begin n_fail++; $display("FAIL ls_err[%0d] got=%b exp=%b", i, er, e.err); end
        end
    endtask

    task automatic test_errors();
        txn_t q[$];
        logic [31:0] rd;
        logic er;
        int lat;
        bit tmo;
        exp_t e;
        q.push_back(mk(1'b0, 3'b010, 32'h12, 32'h0, 32'h0, 1'b1));
        q.push_back(mk(1'b0, 3'b001, 32'h11, 32'h0, 32'h0, 1'b1));
        q.push_back(mk(1'b1, 3'b010, 32'h400, 32'h77777777, 32'h0, 1'b1));
        q.push_back(mk(1'b0, 3'b011, 32'h10, 32'h0, 32'h0, 1'b1));
        q.push_back(mk(1'b1, 3'b010, 32'h12, 32'h99999999, 32'h0, 1'b1));
        q.push_back(mk(1'b1, 3'b001, 32'h11, 32'h88888888, 32'h0, 1'b1));
        q.push_back(mk(1'b1, 3'b100, 32'h10, 32'h66666666, 32'h0, 1'b1));
        q.push_back(mk(1'b0, 3'b110, 32'h10, 32'h0, 32'h0, 1'b1));
        q.push_back(mk(1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD55EF, 1'b0));
        foreach (q[i]) begin
            sb.push_back('{rdata: q[i].exp, err: q[i].err});
            run_txn(q[i], rd, er, lat, tmo);
            e = sb.pop_front();
            n_checks++;
            if (tmo || lat != WAITC) begin
                n_fail++; $display("FAIL err_latency[%0d] got=%0d timeout=%0b exp=%0d", i, lat, tmo, WAITC);
            end
            n_checks++;
            if (rd !== e.rdata) begin n_fail++; $display("FAIL err_rdata[%0d] got=%h exp=%h", i, rd, e.rdata); end
            n_checks++;
            if (er !== e.err) begin n_fail++; $display("FAIL err_flag[%0d] got=%b exp=%b", i, er, e.err); end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int lat;
        logic [31:0] rd;
        logic er;
        bit tmo;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_wdata = '0; req_fun3 = 3'b010;
        sb.push_back('{rdata: 32'hDEAD55EF, err: 1'b0});
        @(posedge clk);
        #1;
        req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hCAFEF00D; req_fun3 = 3'b010;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        n_checks++;
        if (lat != WAITC) begin n_fail++; $display("FAIL bp_latency got=%0d exp=%0d", lat, WAITC); end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== e.err || req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got valid=%b rdata=%h err=%b ready=%b exp valid=1 rdata=%h err=%b ready=0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready, e.rdata, e.err);
            end
            @(posedge clk);
            #1;
        end
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release got valid=%b ready=%b exp valid=0 ready=1", rsp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_next_accept got ready=%b exp=0", req_ready); end
        lat = 1;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        e = sb.pop_front();
        n_checks++;
        if (lat != WAITC + 1 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
            n_fail++;
            $display("FAIL bp_store_rsp got lat=%0d rdata=%h err=%b exp lat=%0d rdata=%h err=%b",
                     lat - 1, rsp_rdata, rsp_err, WAITC, e.rdata, e.err);
        end
        @(negedge clk);
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        sb.push_back('{rdata: 32'hCAFEF00D, err: 1'b0});
        run_txn(mk(1'b0, 3'b010, 32'h40, 32'h0, 32'hCAFEF00D, 1'b0), rd, er, lat, tmo);
        e = sb.pop_front();
        n_checks++;
        if (tmo || rd !== e.rdata || er !== e.err) begin
            n_fail++; $display("FAIL bp_readback got=%h err=%b timeout=%b exp=%h", rd, er, tmo, e.rdata);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd;
        logic er;
        int lat;
        bit tmo;
        bit seen;
        exp_t e;
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        run_txn(mk(1'b1, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0), rd, er, lat, tmo);
        e = sb.pop_front();
        n_checks++;
        if (tmo || rd !== e.rdata || er !== e.err) begin
            n_fail++; $display("FAIL abort_prefill got=%h err=%b timeout=%b exp=%h", rd, er, tmo, e.rdata);
        end
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_fun3 = 3'b010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        n_checks++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL abort_accept got ready=%b exp=0", req_ready); end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            n_fail++; $display("FAIL abort_reset got valid=%b ready=%b exp valid=0 ready=1", rsp_valid, req_ready);
        end
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_rsp got rsp_valid seen=%b exp=0", seen); end
        sb.push_back('{rdata: 32'h0, err: 1'b0});
        run_txn(mk(1'b0, 3'b010, 32'h20, 32'h0, 32'h0, 1'b0), rd, er, lat, tmo);
        e = sb.pop_front();
        n_checks++;
        if (tmo || rd !== e.rdata || er !== e.err) begin
            n_fail++; $display("FAIL abort_readback got=%h err=%b timeout=%b exp=%h", rd, er, tmo, e.rdata);
        end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_fun3 = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_loads_stores();
        test_errors();
        test_back_to_back();
        test_reset_abort();
        n_checks++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_drain got=%0d exp=0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
